// File: rtl/nlfsr_prng_gen.sv
// nlfsr_prng_gen -- nonlinear-feedback shift register pseudo-random word generator.
//
// Holds a WIDTH-bit NLFSR state. Every output word advances the state by STEPS
// single-bit steps, which are unrolled into a combinational chain. The block
// must be seeded before it produces anything. Every RESEED_INTERVAL words it
// stops and waits for fresh seed material. Fresh seed material is XORed into
// the running state, so the entropy that was already there is kept.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous reset, active low
//   seed_valid  in   seed offered
//   seed_data   in   seed value (WIDTH)
//   seed_ready  out  seed accepted when seed_valid & seed_ready
//   out_valid   out  out_data holds an unconsumed word
//   out_ready   in   consumer takes the word when out_valid & out_ready
//   out_data    out  registered random word (WIDTH)
//   reseed_req  out  high while the generator waits for mandatory reseed
//   word_count  out  words produced since the last seed, saturating (32)

// One NLFSR step: shift left and insert the nonlinear feedback bit at bit 0.
module nlfsr_prng_gen_step #(
    parameter int WIDTH = 256
) (
    input  logic [WIDTH-1:0] s_i,
    output logic [WIDTH-1:0] s_o
);
    logic fb;

    // The two AND terms make the feedback nonlinear. One AND term uses the
    // top bits and the other uses the two bits around the midpoint.
    assign fb = s_i[WIDTH-1] ^ s_i[WIDTH-4]
              ^ (s_i[WIDTH-2] & s_i[WIDTH-3])
              ^ (s_i[WIDTH/2] & s_i[WIDTH/2-1])
              ^ s_i[1] ^ s_i[0];

    assign s_o = {s_i[WIDTH-2:0], fb};
endmodule

module nlfsr_prng_gen #(
    parameter int          WIDTH           = 256,  // even, 16..1024
    parameter int          STEPS           = 1,    // 1..8 steps per word
    parameter int unsigned RESEED_INTERVAL = 1024  // 0 = never force reseed
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_valid,
    input  logic [WIDTH-1:0] seed_data,
    output logic             seed_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             reseed_req,
    output logic [31:0]      word_count
);
    // The all-zero state is a fixed point of the step function. Any zero
    // value headed for the state register is replaced by 0101..01.
    localparam logic [WIDTH-1:0] ZERO_FIX   = {(WIDTH/2){2'b01}};
    localparam logic [31:0]      RESEED_CNT = 32'(RESEED_INTERVAL);
    localparam bit               RESEED_EN  = (RESEED_INTERVAL != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        RESEED = 2'd2
    } fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             vld_q, vld_d;
    logic [31:0]      cnt_q, cnt_d;
    logic             rdy_q;

    logic             seed_hs;
    logic             gen;
    logic             take;
    logic [31:0]      cnt_inc;
    logic [WIDTH-1:0] next_word;

    // The unrolled step chain. chain[0] is the current state and
    // chain[STEPS] is f^STEPS(state).
    logic [STEPS:0][WIDTH-1:0] chain;

    assign chain[0] = state_q;

    for (genvar g = 0; g < STEPS; g++) begin : g_step
        nlfsr_prng_gen_step #(
            .WIDTH (WIDTH)
        ) u_step (
            .s_i (chain[g]),
            .s_o (chain[g+1])
        );
    end

    function automatic logic [WIDTH-1:0] zguard(input logic [WIDTH-1:0] v);
        return (v == '0) ? ZERO_FIX : v;
    endfunction

    assign next_word = zguard(chain[STEPS]);
    assign seed_hs   = seed_valid & rdy_q;
    assign take      = vld_q & out_ready;
    // A seed handshake takes priority over generating a word.
    assign gen       = (fsm_q == RUN) & (~vld_q | out_ready) & ~seed_hs;
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;

    // Next-state and datapath control.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        // An accepted word is consumed. Generating a word overrides this below.
        vld_d   = vld_q & ~take;

        case (fsm_q)
            IDLE: begin
                if (seed_hs) begin
                    state_d = zguard(seed_data);
                    cnt_d   = '0;
                    fsm_d   = RUN;
                end
            end

            RUN: begin
                if (seed_hs) begin
                    state_d = zguard(state_q ^ seed_data);
                    cnt_d   = '0;
                end else if (gen) begin
                    state_d = next_word;
                    data_d  = next_word;
                    vld_d   = 1'b1;
                    cnt_d   = cnt_inc;
                    if (RESEED_EN && (cnt_inc == RESEED_CNT)) begin
                        fsm_d = RESEED;
                    end
                end
            end

            RESEED: begin
                // No words are generated here. A word already in out_data
                // still drains through the default consume path above.
                if (seed_hs) begin
                    state_d = zguard(state_q ^ seed_data);
                    cnt_d   = '0;
                    fsm_d   = RUN;
                end
            end

            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
            // Seeds are always accepted once the block is out of reset.
            rdy_q   <= 1'b1;
        end
    end

    assign seed_ready = rdy_q;
    assign out_valid  = vld_q;
    assign out_data   = data_q;
    assign word_count = cnt_q;
    assign reseed_req = (fsm_q == RESEED);
endmodule

// File: doc/nlfsr_prng_gen.md
NLFSR_PRNG_GEN -- requirements
Module: nlfsr_prng_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 256, state/output width; even, 16..1024.
REQ-002 SHALL have parameter STEPS, default 1, NLFSR steps per output word; 1..8, unrolled combinationally.
REQ-003 SHALL have parameter RESEED_INTERVAL, default 1024, words between mandatory reseeds; 0 disables reseeding.
REQ-004 SHALL have port clk  input  1  clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port seed_valid  input  1  seed offered.
REQ-007 SHALL have port seed_data  input  WIDTH  seed value.
REQ-008 SHALL have port seed_ready  output  1  seed accepted when seed_valid & seed_ready.
REQ-009 SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-010 SHALL have port out_ready  input  1  consumer accepts word when out_valid & out_ready.
REQ-011 SHALL have port out_data  output  WIDTH  random word, registered.
REQ-012 SHALL have port reseed_req  output  1  high while in RESEED state.
REQ-013 SHALL have port word_count  output  32  words produced since last seed, saturating at 2^32-1.

Function
REQ-014 SHALL define one step f(s) = {s[WIDTH-2:0], fb}, fb = s[W-1]^s[W-4]^(s[W-2]&s[W-3])^(s[W/2]&s[W/2-1])^s[1]^s[0], W=WIDTH.
REQ-015 SHALL define ZERO_FIX = repeated 2'b01 pattern (bit 0 = 1); any value about to be written to state that is all-zero SHALL be replaced by ZERO_FIX.
REQ-016 SHALL implement FSM states IDLE, RUN, RESEED; seed_ready = 1 in all states outside reset.
REQ-017 IDLE: no words generated; seed handshake -> state <= seed_data (zero-guarded), word_count <= 0, go RUN.
REQ-018 RUN: generate step when (!out_valid | out_ready) and no seed handshake this cycle: state <= f^STEPS(state), out_data <= same value, out_valid <= 1, word_count += 1.
REQ-019 RUN: out_valid & out_ready with no generate step (seed handshake cycle) SHALL clear out_valid.
REQ-020 RUN: seed handshake SHALL take priority over generation: state <= state ^ seed_data (zero-guarded), word_count <= 0, no word produced that cycle.
REQ-021 RUN -> RESEED on the edge where a generate step makes word_count equal RESEED_INTERVAL (RESEED_INTERVAL != 0).
REQ-022 RESEED: no generation; out_data/out_valid drain normally via out_ready; seed handshake -> state <= state ^ seed_data (zero-guarded), word_count <= 0, go RUN.
REQ-023 First word after IDLE seed accept at edge N SHALL appear out_valid=1 at edge N+1 with out_data = f^STEPS(seed); sustained throughput 1 word/cycle with out_ready held high.
REQ-024 out_data SHALL hold stable while out_valid & !out_ready.
REQ-025 With RESEED_INTERVAL = 0 the block SHALL never enter RESEED; word_count saturates.

Reset
REQ-026 rst low SHALL asynchronously force: FSM IDLE, state 0, out_data 0, out_valid 0, reseed_req 0, word_count 0, seed_ready 0.
REQ-027 Reset mid-operation SHALL discard any pending word and seed; after release block requires a new seed.

Verification
REQ-028 WIDTH=16, STEPS=1: seed 0x0001 in IDLE, out_ready=1 -> out_data 0x0003 then 0x0006, one per cycle, word_count 1,2.
REQ-029 WIDTH=16: seed 0x0000 -> state 0x5555; first out_data 0xAAAA.
REQ-030 WIDTH=16, RESEED_INTERVAL=2: after 2 words reseed_req=1, no third word until seed 0x00FF accepted; then state = 0x0006^0x00FF = 0x00F9, RUN resumes, word_count restarts at 0.
REQ-031 Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_data, state, word_count unchanged; release -> next word next cycle.
REQ-032 Seed in RUN while out_ready=1: no new word that cycle, out_valid drops to 0, next cycle word = f(old_state ^ seed).
REQ-033 Assert rst during RUN with out_valid=1 -> all outputs zero immediately; no output until new seed accepted.
